// File: rtl/ctrl_pipe_hazard_unit.sv
// Pipeline control for a 5-stage core: carries decoder controls through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards and resolves branches (EX) and jumps (ID).
module ctrl_pipe_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_reg_dst,
  input  logic               id_jump,
  input  logic               id_branch,
  input  logic               id_branch_ne,
  input  logic               id_mem_read,
  input  logic               id_mem_to_reg,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_zero,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [REG_AW-1:0]  ex_wr_reg,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               mem_reg_write,
  output logic [REG_AW-1:0]  mem_wr_reg,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_wr_reg,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic [1:0]         pc_src
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  typedef struct packed {
    logic               reg_dst;
    logic               branch;
    logic               branch_ne;
    logic               mem_read;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] wr_reg;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] wr_reg;
  } memwb_t;

  idex_t   idex_d, idex_q;
  exmem_t  exmem_q;
  memwb_t  memwb_q;
  logic    load_use, branch_taken, take_jump, inject_bubble;
  pc_sel_e pc_sel;

  assign ex_wr_reg = idex_q.reg_dst ? idex_q.rd : idex_q.rt;

  // A write to $0 is architecturally discarded, so it can never create a load-use hazard.
  assign load_use = idex_q.mem_read & idex_q.reg_write & (ex_wr_reg != '0) &
                    ((ex_wr_reg == id_rs) | (ex_wr_reg == id_rt));
  assign branch_taken  = idex_q.branch & (ex_zero ^ idex_q.branch_ne);
  assign take_jump     = rst_n & id_valid & id_jump & ~load_use & ~branch_taken;
  assign inject_bubble = ~id_valid | load_use | branch_taken;

  always_comb begin
    idex_d            = '0;
    idex_d.reg_dst    = id_reg_dst;
    idex_d.branch     = id_branch;
    idex_d.branch_ne  = id_branch_ne;
    idex_d.mem_read   = id_mem_read;
    idex_d.mem_to_reg = id_mem_to_reg;
    idex_d.alu_op     = id_alu_op;
    idex_d.mem_write  = id_mem_write;
    idex_d.alu_src    = id_alu_src;
    idex_d.reg_write  = id_reg_write;
    idex_d.rt         = id_rt;
    idex_d.rd         = id_rd;
  end

  // NOTE: every output gets a default before the priority chain, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    pc_sel     = PC_SEQ;
    if (branch_taken) begin
      pc_sel     = PC_BRANCH;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (take_jump) begin
      pc_sel     = PC_JUMP;
      ifid_flush = 1'b1;
    end
  end

  assign pc_src = pc_sel;

  // NOTE: pipeline registers use non-blocking assignments so each stage samples the
  // previous stage's value from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q             <= inject_bubble ? '0 : idex_d;
      exmem_q.mem_read   <= idex_q.mem_read;
      exmem_q.mem_write  <= idex_q.mem_write;
      exmem_q.reg_write  <= idex_q.reg_write;
      exmem_q.mem_to_reg <= idex_q.mem_to_reg;
      exmem_q.wr_reg     <= ex_wr_reg;
      memwb_q.reg_write  <= exmem_q.reg_write;
      memwb_q.mem_to_reg <= exmem_q.mem_to_reg;
      memwb_q.wr_reg     <= exmem_q.wr_reg;
    end
  end

  assign ex_alu_op     = idex_q.alu_op;
  assign ex_alu_src    = idex_q.alu_src;
  assign mem_mem_read  = exmem_q.mem_read;
  assign mem_mem_write = exmem_q.mem_write;
  assign mem_reg_write = exmem_q.reg_write;
  assign mem_wr_reg    = exmem_q.wr_reg;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_wr_reg     = memwb_q.wr_reg;

endmodule

// File: tb/tb_ctrl_pipe_hazard_unit.sv
// Bench for ctrl_pipe_hazard_unit: directed hazard scenarios followed by random
// instruction streams, checked against an instruction-level pipeline model.
module tb_ctrl_pipe_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       bne;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  logic       clk, rst_n;
  logic       id_valid, id_reg_dst, id_jump, id_branch, id_branch_ne, id_mem_read;
  logic       id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, ex_zero;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src;
  logic [4:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic       mem_mem_read, mem_mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg;
  logic       pc_we, ifid_we, ifid_flush;
  logic [1:0] pc_src;

  int vectors = 0;
  int miscompares = 0;

  // In-flight instructions as seen by the model: [0]=EX, [1]=MEM, [2]=WB.
  instr_t pipe [3];
  logic   last_stall;

  ctrl_pipe_hazard_unit #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
    .id_jump(id_jump), .id_branch(id_branch), .id_branch_ne(id_branch_ne),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_wr_reg(ex_wr_reg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_wr_reg(mem_wr_reg),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_wr_reg(wb_wr_reg),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .pc_src(pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t i = '0;
    i.valid = 1'b1;
    return i;
  endfunction

  function automatic instr_t rtype(input logic [4:0] rs, rt, rd);
    instr_t i = nop();
    i.reg_dst = 1'b1; i.alu_op = 2'b10; i.reg_write = 1'b1;
    i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] rs, rt);
    instr_t i = nop();
    i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1;
    i.rs = rs; i.rt = rt; i.rd = 5'($urandom_range(0, 31));
    return i;
  endfunction

  function automatic instr_t sw(input logic [4:0] rs, rt);
    instr_t i = nop();
    i.mem_write = 1'b1; i.alu_src = 1'b1; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t br(input logic [4:0] rs, rt, input logic ne);
    instr_t i = nop();
    i.branch = 1'b1; i.bne = ne; i.alu_op = 2'b01; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t jmp(input logic [4:0] rs);
    instr_t i = nop();
    i.jump = 1'b1; i.rs = rs;
    return i;
  endfunction

  function automatic logic [4:0] dest(input instr_t i);
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: i = rtype(a, b, c);
      1: i = lw(a, b);
      2: i = sw(a, b);
      3: i = br(a, b, 1'($urandom_range(0, 1)));
      4: i = jmp(a);
      default: begin
        i = nop(); i.alu_src = 1'b1; i.reg_write = 1'b1; i.rs = a; i.rt = b; i.rd = c;
      end
    endcase
    i.valid = ($urandom_range(0, 9) != 0);
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic zero);
    id_valid = i.valid; id_reg_dst = i.reg_dst; id_jump = i.jump; id_branch = i.branch;
    id_branch_ne = i.bne; id_mem_read = i.mem_read; id_mem_to_reg = i.mem_to_reg;
    id_alu_op = i.alu_op; id_mem_write = i.mem_write; id_alu_src = i.alu_src;
    id_reg_write = i.reg_write; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; ex_zero = zero;
  endtask

  task automatic check_stages();
    check("ex_alu_op",     ex_alu_op,     pipe[0].alu_op);
    check("ex_alu_src",    ex_alu_src,    pipe[0].alu_src);
    check("ex_wr_reg",     ex_wr_reg,     dest(pipe[0]));
    check("mem_mem_read",  mem_mem_read,  pipe[1].mem_read);
    check("mem_mem_write", mem_mem_write, pipe[1].mem_write);
    check("mem_reg_write", mem_reg_write, pipe[1].reg_write);
    check("mem_wr_reg",    mem_wr_reg,    dest(pipe[1]));
    check("wb_reg_write",  wb_reg_write,  pipe[2].reg_write);
    check("wb_mem_to_reg", wb_mem_to_reg, pipe[2].mem_to_reg);
    check("wb_wr_reg",     wb_wr_reg,     dest(pipe[2]));
  endtask

  // One clock: present the ID word, check against the model, then advance the model.
  task automatic cycle(input instr_t in, input logic zero);
    instr_t     e;
    logic [4:0] w;
    logic       hazard, taken, jumps;
    drive(in, zero);
    #1;
    e      = pipe[0];
    w      = dest(e);
    hazard = e.mem_read && e.reg_write && (w != 5'd0) && (w == in.rs || w == in.rt);
    taken  = e.branch && (zero != e.bne);
    jumps  = in.valid && in.jump && !hazard && !taken;
    check("pc_we",      pc_we,      (hazard && !taken) ? 0 : 1);
    check("ifid_we",    ifid_we,    (hazard && !taken) ? 0 : 1);
    check("ifid_flush", ifid_flush, (taken || jumps) ? 1 : 0);
    check("pc_src",     pc_src,     taken ? 2'b01 : (jumps ? 2'b10 : 2'b00));
    check_stages();
    last_stall = hazard && !taken;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (in.valid && !hazard && !taken) ? in : '0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_alu_op"},     ex_alu_op,     0);
    check({tag, "_ex_alu_src"},    ex_alu_src,    0);
    check({tag, "_ex_wr_reg"},     ex_wr_reg,     0);
    check({tag, "_mem_mem_read"},  mem_mem_read,  0);
    check({tag, "_mem_mem_write"}, mem_mem_write, 0);
    check({tag, "_mem_reg_write"}, mem_reg_write, 0);
    check({tag, "_mem_wr_reg"},    mem_wr_reg,    0);
    check({tag, "_wb_reg_write"},  wb_reg_write,  0);
    check({tag, "_wb_mem_to_reg"}, wb_mem_to_reg, 0);
    check({tag, "_wb_wr_reg"},     wb_wr_reg,     0);
    check({tag, "_pc_we"},         pc_we,         1);
    check({tag, "_ifid_we"},       ifid_we,       1);
    check({tag, "_ifid_flush"},    ifid_flush,    0);
    check({tag, "_pc_src"},        pc_src,        0);
  endtask

  initial begin
    instr_t w, cur;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    last_stall = 1'b0;

    // Reset with a jump sitting in ID: outputs must stay in their reset values.
    rst_n = 1'b0;
    drive(jmp(5'd0), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // R-type rd=3 flows EX -> MEM -> WB.
    cycle(rtype(5'd1, 5'd2, 5'd3), 1'b0);
    check("t1_ex_alu_op", ex_alu_op, 2'b10);
    cycle(nop(), 1'b0);
    check("t1_mem_reg_write", mem_reg_write, 1);
    check("t1_mem_wr_reg", mem_wr_reg, 3);
    cycle(nop(), 1'b0);
    check("t1_wb_reg_write", wb_reg_write, 1);
    check("t1_wb_wr_reg", wb_wr_reg, 3);

    // Load-use: lw $5 then add using $5, re-presented after the stall.
    cycle(lw(5'd1, 5'd5), 1'b0);
    cycle(rtype(5'd5, 5'd6, 5'd7), 1'b0);
    cycle(rtype(5'd5, 5'd6, 5'd7), 1'b0);
    cycle(nop(), 1'b0);

    // beq taken, beq not taken, bne taken.
    cycle(br(5'd1, 5'd2, 1'b0), 1'b0);
    cycle(rtype(5'd1, 5'd2, 5'd4), 1'b1);
    cycle(br(5'd1, 5'd2, 1'b0), 1'b0);
    cycle(rtype(5'd1, 5'd2, 5'd4), 1'b0);
    cycle(br(5'd1, 5'd2, 1'b1), 1'b0);
    cycle(rtype(5'd1, 5'd2, 5'd4), 1'b0);

    // Taken branch beats a simultaneous load-use condition and a jump in ID.
    w = br(5'd0, 5'd5, 1'b0);
    w.mem_read = 1'b1; w.reg_write = 1'b1;
    cycle(w, 1'b0);
    cycle(jmp(5'd5), 1'b1);

    // lw to $0 never stalls; a jump flushes for exactly one cycle.
    cycle(lw(5'd1, 5'd0), 1'b0);
    cycle(rtype(5'd0, 5'd4, 5'd6), 1'b0);
    cycle(jmp(5'd9), 1'b0);
    cycle(nop(), 1'b0);

    // Asynchronous reset with three valid instructions in flight.
    cycle(rtype(5'd1, 5'd2, 5'd10), 1'b0);
    cycle(lw(5'd3, 5'd11), 1'b0);
    cycle(rtype(5'd4, 5'd5, 5'd12), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stream; a stalled ID instruction is presented again, as IF/ID would hold it.
    cur = rand_instr();
    for (int n = 0; n < 400; n++) begin
      cycle(cur, 1'($urandom_range(0, 1)));
      if (!last_stall) cur = rand_instr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
